// File: rtl/memory_arbiter_if.sv
// ---------------------------------------------------------------------------
// memory_arbiter_if
//
// Bundles every handshake and bus signal around memory_arbiter: the two
// master request/done channels and the single-port RAM connection.
//
//   master side (per port n = 0/1):
//     request<n>, write<n>, address<n>, write_data<n>  -> arbiter
//     done<n>, read_data<n>                            <- arbiter
//   RAM side:
//     ram_address, ram_data_out,
//     ram_read_enabled, ram_write_enabled              <- arbiter
//     ram_data_in (registered RAM read data)           -> arbiter
//
// Modports:
//   slave  - the arbiter's view (it serves the masters and drives the RAM)
//   master - the environment's view (masters plus the RAM model)
// ---------------------------------------------------------------------------
interface memory_arbiter_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
);
    logic                     request0;
    logic                     request1;
    logic                     write0;
    logic                     write1;
    logic [ADDRESS_WIDTH-1:0] address0;
    logic [ADDRESS_WIDTH-1:0] address1;
    logic [DATA_WIDTH-1:0]    write_data0;
    logic [DATA_WIDTH-1:0]    write_data1;
    logic                     done0;
    logic                     done1;
    logic [DATA_WIDTH-1:0]    read_data0;
    logic [DATA_WIDTH-1:0]    read_data1;

    logic [ADDRESS_WIDTH-1:0] ram_address;
    logic [DATA_WIDTH-1:0]    ram_data_out;
    logic [DATA_WIDTH-1:0]    ram_data_in;
    logic                     ram_read_enabled;
    logic                     ram_write_enabled;

    modport slave (
        input  request0, request1, write0, write1,
        input  address0, address1, write_data0, write_data1,
        output done0, done1, read_data0, read_data1,
        output ram_address, ram_data_out, ram_read_enabled, ram_write_enabled,
        input  ram_data_in
    );

    modport master (
        output request0, request1, write0, write1,
        output address0, address1, write_data0, write_data1,
        input  done0, done1, read_data0, read_data1,
        input  ram_address, ram_data_out, ram_read_enabled, ram_write_enabled,
        output ram_data_in
    );
endinterface

// File: rtl/memory_arbiter.sv
// ---------------------------------------------------------------------------
// memory_arbiter
//
// Two-master arbiter in front of a single-port RAM with registered read
// data. Each access walks IDLE -> ACCESS -> WAIT -> DONE, so one access is
// completed every four cycles. The granted master gets a one-cycle done
// pulse; reads also update that master's read_data, which then holds until
// the same port's next read completes.
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - memory_arbiter_if.slave: master request/done channels and the
//          RAM address/data/enable signals
//
// Configuration macro:
//   MEMORY_ARBITER_ROUND_ROBIN_EN
//     defined     - on a tie, grant the port that was not granted last
//     not defined - fixed priority, port 0 wins every tie
// ---------------------------------------------------------------------------
module memory_arbiter #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    memory_arbiter_if.slave      bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state_reg;
    logic   port_reg;     // granted port of the access in flight
    logic   write_reg;    // latched operation of the access in flight

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    logic   last_grant_reg;
`endif

    // Port selection for the current IDLE cycle and the matching request
    // fields. A lone requester always wins; only a tie consults the policy.
    logic                     grant_port;
    logic                     sel_write;
    logic [ADDRESS_WIDTH-1:0] sel_address;
    logic [DATA_WIDTH-1:0]    sel_write_data;

    always_comb begin
        grant_port = 1'b0;
        if (bus.request0 && bus.request1) begin
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
            grant_port = ~last_grant_reg;
`else
            grant_port = 1'b0;
`endif
        end else if (bus.request1) begin
            grant_port = 1'b1;
        end

        sel_write      = grant_port ? bus.write1      : bus.write0;
        sel_address    = grant_port ? bus.address1    : bus.address0;
        sel_write_data = grant_port ? bus.write_data1 : bus.write_data0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg             <= IDLE;
            port_reg              <= 1'b0;
            write_reg             <= 1'b0;
            bus.done0             <= 1'b0;
            bus.done1             <= 1'b0;
            bus.read_data0        <= '0;
            bus.read_data1        <= '0;
            bus.ram_address       <= '0;
            bus.ram_data_out      <= '0;
            bus.ram_read_enabled  <= 1'b0;
            bus.ram_write_enabled <= 1'b0;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
            last_grant_reg        <= 1'b1;
`endif
        end else begin
            // done is a single-cycle pulse: cleared unless set below
            bus.done0 <= 1'b0;
            bus.done1 <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (bus.request0 || bus.request1) begin
                        port_reg  <= grant_port;
                        write_reg <= sel_write;
                        // Address/data stay latched after ACCESS; only the
                        // enables, raised for exactly the ACCESS cycle,
                        // qualify the RAM operation.
                        bus.ram_address       <= sel_address;
                        bus.ram_data_out      <= sel_write_data;
                        bus.ram_read_enabled  <= ~sel_write;
                        bus.ram_write_enabled <= sel_write;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
                        last_grant_reg        <= grant_port;
`endif
                        state_reg <= ACCESS;
                    end
                end

                ACCESS: begin
                    // RAM samples the enables at the end of this cycle
                    bus.ram_read_enabled  <= 1'b0;
                    bus.ram_write_enabled <= 1'b0;
                    state_reg             <= WAIT;
                end

                WAIT: begin
                    // ram_data_in is valid now; registering it here makes
                    // read_data and done appear together in DONE.
                    if (port_reg) begin
                        bus.done1 <= 1'b1;
                        if (!write_reg) begin
                            bus.read_data1 <= bus.ram_data_in;
                        end
                    end else begin
                        bus.done0 <= 1'b1;
                        if (!write_reg) begin
                            bus.read_data0 <= bus.ram_data_in;
                        end
                    end
                    state_reg <= DONE;
                end

                DONE: begin
                    // Masters drop request during the following cycle, so
                    // IDLE only sees requests that are genuinely new.
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// ---------------------------------------------------------------------------
// tb_memory_arbiter
//
// Scoreboard bench for memory_arbiter. Each request pushes the expected done
// cycle (and read data) onto a per-port queue; the per-cycle monitor pops an
// entry on every done pulse and compares. read_data is checked every cycle
// against the last value that port is expected to hold. A small RAM model
// with registered read data sits on the RAM side of the interface.
// Arbitration expectations follow MEMORY_ARBITER_ROUND_ROBIN_EN.
// ---------------------------------------------------------------------------
module tb_memory_arbiter;
    localparam int AW = 16;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    memory_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    memory_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- RAM model: 256 words, registered read -----------------
    logic [DW-1:0] mem [0:255];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 + i;
        mem[3] = 32'h1234_5678;
    end

    always @(posedge clk) begin
        if (bus.ram_write_enabled && bus.ram_address < 16'd256)
            mem[bus.ram_address[7:0]] <= bus.ram_data_out;
        if (bus.ram_read_enabled)
            bus.ram_data_in <= (bus.ram_address < 16'd256) ? mem[bus.ram_address[7:0]]
                                                           : 32'hBAD0_BAD0;
    end

    // ---------------- scoreboard state ----------------
    typedef struct {
        int          cycle;
        bit          rd;
        logic [31:0] data;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int          compared   = 0;
    int          mismatched = 0;
    int          cyc        = 0;
    int          wr_pulses  = 0;
    logic [31:0] exp_rd0    = '0;
    logic [31:0] exp_rd1    = '0;
    bit          pend0 = 0, pend1 = 0;
    int          hold0 = 0, hold1 = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        check("en_excl", bus.ram_read_enabled & bus.ram_write_enabled, 0);
        if (bus.ram_write_enabled) wr_pulses++;
        if (bus.done0) begin
            pend0 = 1;
            if (q0.size() == 0) check("done0_spurious", 1, 0);
            else begin
                e = q0.pop_front();
                check("done0_cycle", cyc, e.cycle);
                if (e.rd) exp_rd0 = e.data;
                $display("cycle %0d: port0 %s done, read_data0=0x%08h", cyc,
                         e.rd ? "read" : "write", bus.read_data0);
            end
        end
        if (bus.done1) begin
            pend1 = 1;
            if (q1.size() == 0) check("done1_spurious", 1, 0);
            else begin
                e = q1.pop_front();
                check("done1_cycle", cyc, e.cycle);
                if (e.rd) exp_rd1 = e.data;
                $display("cycle %0d: port1 %s done, read_data1=0x%08h", cyc,
                         e.rd ? "read" : "write", bus.read_data1);
            end
        end
        check("rdata0", bus.read_data0, exp_rd0);
        check("rdata1", bus.read_data1, exp_rd1);
    endtask

    // One clock: inputs change 1 ns after the edge, outputs sampled on negedge.
    // A master drops request in the cycle after its done unless held.
    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        if (pend0) begin
            pend0 = 0;
            if (hold0 > 0) hold0--; else bus.request0 = 1'b0;
        end
        if (pend1) begin
            pend1 = 0;
            if (hold1 > 0) hold1--; else bus.request1 = 1'b0;
        end
        @(negedge clk);
        if (!rst) monitor();
    endtask

    // Raise a request in the current cycle and expect done lat cycles later.
    // For reads, d is the expected read data.
    task automatic req(input int port, input bit wr, input logic [15:0] a,
                       input logic [31:0] d, input int lat);
        exp_t e;
        e.cycle = cyc + lat;
        e.rd    = !wr;
        e.data  = d;
        if (port == 0) begin
            bus.write0 = wr; bus.address0 = a; bus.write_data0 = d; bus.request0 = 1'b1;
            q0.push_back(e);
        end else begin
            bus.write1 = wr; bus.address1 = a; bus.write_data1 = d; bus.request1 = 1'b1;
            q1.push_back(e);
        end
    endtask

    // Extra expected completion for a request held high across its done.
    task automatic expect_more(input int port, input logic [31:0] d, input int lat);
        exp_t e;
        e.cycle = cyc + lat;
        e.rd    = 1'b1;
        e.data  = d;
        if (port == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (q0.size() != 0 || q1.size() != 0 || bus.request0 || bus.request1) begin
            step();
            n++;
            if (n > 60) begin
                check("drain_timeout", 1, 0);
                q0.delete(); q1.delete();
                bus.request0 = 1'b0; bus.request1 = 1'b0;
                hold0 = 0; hold1 = 0;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.request0 = 0; bus.request1 = 0; bus.write0 = 0; bus.write1 = 0;
        bus.address0 = '0; bus.address1 = '0; bus.write_data0 = '0; bus.write_data1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        check("rst_ctrl", {bus.done0, bus.done1, bus.ram_read_enabled, bus.ram_write_enabled}, 0);
        check("rst_rdata0", bus.read_data0, 0);
        check("rst_rdata1", bus.read_data1, 0);
        check("rst_ram_addr", bus.ram_address, 0);
        check("rst_ram_dout", bus.ram_data_out, 0);
        rst = 1'b0;
        step();

        // First tie after reset: port 0 wins either way
        req(0, 0, 16'h0020, 32'hA500_0020, 3);
        req(1, 0, 16'h0021, 32'hA500_0021, 7);
        drain();

        // Port 0 write then read-back
        wr_pulses = 0;
        req(0, 1, 16'h0010, 32'hDEAD_BEEF, 3);
        drain();
        check("wr_pulses", wr_pulses, 1);
        check("ram_word_0010", mem[16], 32'hDEAD_BEEF);
        req(0, 0, 16'h0010, 32'hDEAD_BEEF, 3);
        drain();

        // Tie again, after port 0 was granted last
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
        req(1, 0, 16'h0023, 32'hA500_0023, 3);
        req(0, 0, 16'h0022, 32'hA500_0022, 7);
`else
        req(0, 0, 16'h0022, 32'hA500_0022, 3);
        req(1, 0, 16'h0023, 32'hA500_0023, 7);
`endif
        drain();

        // Port 1 read while port 0 writes: read_data0 untouched
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
        req(1, 0, 16'h0003, 32'h1234_5678, 3);
        req(0, 1, 16'h0040, 32'h0BAD_F00D, 7);
`else
        req(0, 1, 16'h0040, 32'h0BAD_F00D, 3);
        req(1, 0, 16'h0003, 32'h1234_5678, 7);
`endif
        drain();
        repeat (3) step();
        check("rdata1_held", bus.read_data1, 32'h1234_5678);
        check("rdata0_kept", bus.read_data0, 32'hA500_0022);
        check("ram_word_0040", mem[64], 32'h0BAD_F00D);

        // Request held through done: identical second access 4 cycles later
        hold0 = 1;
        req(0, 0, 16'h0010, 32'hDEAD_BEEF, 3);
        expect_more(0, 32'hDEAD_BEEF, 7);
        drain();

        // Out-of-range write and read complete normally
        req(0, 1, 16'hFFFF, 32'h1111_1111, 3);
        drain();
        req(0, 0, 16'hFFFF, 32'hBAD0_BAD0, 3);
        drain();

        // Port 0 requesting continuously against port 1
        hold0 = 3;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
        req(1, 0, 16'h0025, 32'hA500_0025, 3);
        req(0, 0, 16'h0024, 32'hA500_0024, 7);
        expect_more(0, 32'hA500_0024, 11);
        expect_more(0, 32'hA500_0024, 15);
        expect_more(0, 32'hA500_0024, 19);
`else
        req(0, 0, 16'h0024, 32'hA500_0024, 3);
        expect_more(0, 32'hA500_0024, 7);
        expect_more(0, 32'hA500_0024, 11);
        expect_more(0, 32'hA500_0024, 15);
        req(1, 0, 16'h0025, 32'hA500_0025, 19);
`endif
        drain();

        // Reset in WAIT of a read: immediate reset values, no done
        bus.write0 = 1'b0; bus.address0 = 16'h0010; bus.request0 = 1'b1;
        step();
        step();
        rst = 1'b1;
        #1;
        check("midrst_ctrl", {bus.done0, bus.done1, bus.ram_read_enabled, bus.ram_write_enabled}, 0);
        check("midrst_rdata0", bus.read_data0, 0);
        check("midrst_rdata1", bus.read_data1, 0);
        check("midrst_ram_addr", bus.ram_address, 0);
        check("midrst_ram_dout", bus.ram_data_out, 0);
        bus.request0 = 1'b0;
        exp_rd0 = '0; exp_rd1 = '0;
        pend0 = 0; pend1 = 0; hold0 = 0; hold1 = 0;
        step();
        rst = 1'b0;
        step();
        step();
        req(0, 0, 16'h0003, 32'h1234_5678, 3);
        drain();

        check("queues_empty", q0.size() + q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-master arbiter that sits directly upstream of the single-port RAM and is the only block driving the RAM's slave memory interface. Each master issues one read or write at a time with a request/done handshake. The arbiter serialises the accesses, drives the RAM's address, write data and enables, and returns registered read data to the granted master. Throughput is one access per four cycles.

## Interface
- ADDRESS_WIDTH, 16, width of all address buses
- DATA_WIDTH, 32, width of all data buses
- clock  in  1  single clock; everything samples on the rising edge
- reset  in  1  asynchronous, active-high reset
- request0 / request1  in  1  master access request; held high until done
- write0 / write1  in  1  1 = write, 0 = read; valid while request is high
- address0 / address1  in  ADDRESS_WIDTH  access address
- writeData0 / writeData1  in  DATA_WIDTH  write data
- done0 / done1  out  1  one-cycle completion pulse
- readData0 / readData1  out  DATA_WIDTH  read result; holds until that port's next read completes
- ramAddress  out  ADDRESS_WIDTH  to RAM address
- ramDataOut  out  DATA_WIDTH  to RAM write data
- ramDataIn  in  DATA_WIDTH  from RAM; registered read data, valid one cycle after the RAM samples readEnabled
- ramReadEnabled / ramWriteEnabled  out  1  RAM enables; never both high

## Operation
- FSM states:
  - IDLE: samples requests; on any request, latches port, write, address and writeData, then goes to ACCESS.
  - ACCESS: drives ramAddress, ramDataOut and the enable matching the latched op; goes to WAIT.
  - WAIT: all enables low; ramDataIn is valid for reads; goes to DONE.
  - DONE: pulses done for the granted port; for reads, loads that port's readData from ramDataIn captured in WAIT; goes to IDLE.
- Requests are ignored in ACCESS, WAIT and DONE.
- A master lowers request in the cycle after its done pulse. If request is still high in that cycle, it is treated as a new access.
- Arbitration when both requests are high in IDLE is set by the configuration macro.
- lastGrant register resets to 1, so port 0 wins the first tie.
- A single requester is always granted immediately, regardless of lastGrant.
- Writes do not modify readData.
- The arbiter performs no address range check. An out-of-range read completes normally with whatever ramDataIn presents. An out-of-range write completes with done and no RAM effect.
- ramAddress and ramDataOut hold the latched values outside ACCESS. The enables alone qualify an access.

## Timing
- Reset values:
  - state IDLE
  - done0, done1, ramReadEnabled, ramWriteEnabled = 0
  - readData0, readData1, ramAddress, ramDataOut = 0
  - lastGrant = 1
- Reset asserted mid-access: all of the above apply immediately and asynchronously. The in-flight access is dropped without a done pulse. A write already sampled by the RAM is not undone.
- Latency: request high in cycle 0 (state IDLE) gives:
  - ACCESS in cycle 1; the RAM samples at the end of cycle 1
  - WAIT in cycle 2
  - done and readData valid in cycle 3
  - IDLE in cycle 4
- Back-to-back: the next grant is sampled at the end of cycle 4, giving a 4-cycle period.
- A request that arrives during a busy period waits, with no loss, until IDLE.
- Simultaneous requests in IDLE: exactly one grant. The loser is served immediately after, with done at cycle 7.

## Configuration
- MEMORY_ARBITER_ROUND_ROBIN_EN defined: on a tie, grant the port other than lastGrant; lastGrant updates on every grant.
- Not defined: fixed priority. Port 0 always wins a tie, lastGrant is unused, and port 1 can starve under continuous port-0 traffic.

## Test plan
- Port 0 writes 0xDEADBEEF to 0x0010, then reads 0x0010 -> each done0 arrives 3 cycles after its request; readData0 = 0xDEADBEEF; ramWriteEnabled high for exactly one cycle.
- Both ports request reads in the same cycle with the macro defined -> port 0 done at cycle 3, port 1 done at cycle 7. Repeat -> port 1 served first.
- Same tie with the macro undefined and port 0 request held continuously -> done1 never asserts while port 0 keeps requesting.
- Port 1 reads 0x0003 (RAM value 0x12345678) while port 0 writes -> readData0 unchanged; readData1 = 0x12345678 and held after request1 drops.
- Reset asserted in WAIT of a read -> outputs at reset values within the same cycle; no done pulse; the first access after release completes normally with 3-cycle latency.
- Request held high through the done cycle -> a second identical access starts, with done again 4 cycles later.
